bridge_tx_fifo: RTL and testbench

BRIDGE_TX_FIFO -- requirements
Module: bridge_tx_fifo

---
 rtl/manta_bridge_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/bridge_tx_fifo.sv | 136 +++++++++++++
 tb/tb_bridge_tx_fifo.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/manta_bridge_pkg.sv
// Shared constants and helpers for the bus-to-UART bridge.
//   PREAMBLE_DEFAULT : first byte of every message ("D")
//   ASCII_CR/LF      : end-of-line bytes
//   nibble_to_hex    : 4-bit value -> uppercase ASCII hex digit
//   tx_state_e       : transmit FSM state encoding
package manta_bridge_pkg;

  localparam logic [7:0] PREAMBLE_DEFAULT = 8'h44;
  localparam logic [7:0] ASCII_CR         = 8'h0D;
  localparam logic [7:0] ASCII_LF         = 8'h0A;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head output.
//   clk, rst_n      : clock, async active-low reset
//   push_i, data_i  : write request and data (accepted when not full, or
//                     when full but popping the same cycle)
//   pop_i, data_o   : read request and current head entry
//   full_o, empty_o : occupancy flags
//   count_o         : number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A pop frees the slot the write lands in, so a full queue still accepts.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bridge_tx_fifo.sv
// Queues bus read responses and streams each as an ASCII hex line to a UART.
//   clk, rst_n   : clock, async active-low reset
//   data_i       : bus read data
//   rw_i         : 0 = read response (queued), 1 = write (ignored)
//   valid_i      : bus transaction valid
//   data_o       : byte offered to the UART (0 when idle)
//   start_o      : byte request, high for the whole of every message
//   done_i       : UART accepts the offered byte this cycle
//   fifo_count_o : queued entries, not counting the message in flight
//   overflow_o   : sticky, a read response was dropped on a full queue
//
// state | meaning
// IDLE  | nothing to send, waiting for a queued response
// SEND  | streaming message buffer byte idx_q to the UART
module bridge_tx_fifo
  import manta_bridge_pkg::*;
#(
  parameter  int          DATA_WIDTH = 16,
  parameter  int          FIFO_DEPTH = 8,
  parameter  int          EOL_CRLF   = 1,
  parameter  logic [7:0]  PREAMBLE   = PREAMBLE_DEFAULT,
  localparam int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rw_i,
  input  logic                  valid_i,
  output logic [7:0]            data_o,
  output logic                  start_o,
  input  logic                  done_i,
  output logic [CNT_W-1:0]      fifo_count_o,
  output logic                  overflow_o
);

  localparam int NHEX    = DATA_WIDTH / 4;
  localparam int MSG_LEN = 1 + NHEX + ((EOL_CRLF != 0) ? 2 : 1);
  localparam int IDX_W   = $clog2(MSG_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  tx_state_e             state_q;
  logic                  start_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] msg_q;
  logic                  overflow_q, overflow_d;

  logic                  push, pop;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  byte_acc, last_acc;
  logic [3:0]            nib;

  assign push     = valid_i && !rw_i;
  assign byte_acc = start_q && done_i;
  assign last_acc = byte_acc && (idx_q == LAST_IDX);
  // Reload straight from the queue on the last byte so start_o never gaps.
  assign pop      = !fifo_empty && ((state_q == ST_IDLE) || last_acc);

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (data_i),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  assign overflow_d = overflow_q || (push && fifo_full && !pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      idx_q      <= '0;
      msg_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q <= ST_SEND;
            start_q <= 1'b1;
            msg_q   <= fifo_head;
            idx_q   <= '0;
          end
        end
        ST_SEND: begin
          if (byte_acc) begin
            if (idx_q == LAST_IDX) begin
              idx_q <= '0;
              if (!fifo_empty) begin
                msg_q <= fifo_head;
              end else begin
                state_q <= ST_IDLE;
                start_q <= 1'b0;
              end
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          start_q <= 1'b0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign start_o    = start_q;
  assign overflow_o = overflow_q;

  // Byte 1 carries the most significant nibble.
  always_comb begin
    nib = '0;
    for (int k = 0; k < NHEX; k++) begin
      if (idx_q == IDX_W'(k + 1)) nib = msg_q[(NHEX-1-k)*4 +: 4];
    end
    data_o = '0;
    if (state_q == ST_SEND) begin
      if (idx_q == '0)                  data_o = PREAMBLE;
      else if (idx_q <= IDX_W'(NHEX))   data_o = nibble_to_hex(nib);
      else if (idx_q == LAST_IDX)       data_o = ASCII_LF;
      else                              data_o = ASCII_CR;
    end
  end

endmodule

// File: tb/tb_bridge_tx_fifo.sv
module tb_bridge_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        rst_a, rw_a, valid_a, done_a, start_a, ovf_a;
  logic [15:0] din_a;
  logic [7:0]  dout_a;
  logic [3:0]  cnt_a;

  // Instance B: 32-bit data, 4-deep queue, LF-only line ending
  logic        rst_b, rw_b, valid_b, done_b, start_b, ovf_b;
  logic [31:0] din_b;
  logic [7:0]  dout_b;
  logic [2:0]  cnt_b;

  bridge_tx_fifo dut_a (
    .clk(clk), .rst_n(rst_a), .data_i(din_a), .rw_i(rw_a), .valid_i(valid_a),
    .data_o(dout_a), .start_o(start_a), .done_i(done_a),
    .fifo_count_o(cnt_a), .overflow_o(ovf_a)
  );

  bridge_tx_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(4), .EOL_CRLF(0)) dut_b (
    .clk(clk), .rst_n(rst_b), .data_i(din_b), .rw_i(rw_b), .valid_i(valid_b),
    .data_o(dout_b), .start_o(start_b), .done_i(done_b),
    .fifo_count_o(cnt_b), .overflow_o(ovf_b)
  );

  logic [7:0] rx_a[$], rx_b[$], exp_a[$], exp_b[$];

  // Bytes handed over at the next rising edge
  always @(negedge clk) begin
    if (start_a && done_a) rx_a.push_back(dout_a);
    if (start_b && done_b) rx_b.push_back(dout_b);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the line a read response must produce, built from the message rules.
  function automatic void model_msg(input int which, input logic [63:0] d,
                                    input int width, input int crlf);
    string      hx = "0123456789ABCDEF";
    logic [7:0] m[$];
    int         dig;
    m.push_back(8'h44);
    for (int i = 0; i < width / 4; i++) begin
      dig = int'((d >> (4 * (width / 4 - 1 - i))) & 64'hF);
      m.push_back(hx[dig]);
    end
    if (crlf != 0) m.push_back(8'h0D);
    m.push_back(8'h0A);
    foreach (m[i]) begin
      if (which == 0) exp_a.push_back(m[i]);
      else            exp_b.push_back(m[i]);
    end
  endfunction

  task automatic wait_rx(input int which, input int n, input int budget, input string name);
    int sz;
    for (int c = 0; c < budget; c++) begin
      sz = (which == 0) ? rx_a.size() : rx_b.size();
      if (sz >= n) break;
      tick();
    end
    sz = (which == 0) ? rx_a.size() : rx_b.size();
    chk({name, "_timeout"}, 64'(sz >= n), 64'd1);
  endtask

  task automatic cmp_stream(input int which, input string name);
    logic [7:0] r[$];
    logic [7:0] e[$];
    if (which == 0) begin
      r = rx_a; e = exp_a; rx_a.delete(); exp_a.delete();
    end else begin
      r = rx_b; e = exp_b; rx_b.delete(); exp_b.delete();
    end
    chk({name, "_len"}, 64'(r.size()), 64'(e.size()));
    for (int i = 0; i < r.size() && i < e.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), r[i], e[i]);
  endtask

  typedef struct {
    logic [15:0] data;
    string       hex;
  } vec_t;
  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gaps, issued, pending;
    bit started;
    logic [2:0] exp_cnt [6];
    logic       exp_ovf [6];

    vecs[0] = '{16'h1A2F, "1A2F"};
    vecs[1] = '{16'h0000, "0000"};
    vecs[2] = '{16'hFFFF, "FFFF"};
    vecs[3] = '{16'h09C4, "09C4"};
    vecs[4] = '{16'h7E5B, "7E5B"};
    exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    exp_ovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_a = 0; rw_a = 0; valid_a = 0; done_a = 0; din_a = '0;
    rst_b = 0; rw_b = 0; valid_b = 0; done_b = 0; din_b = '0;
    repeat (3) tick();

    chk("rst_start_a", start_a, 0);
    chk("rst_data_a",  dout_a,  0);
    chk("rst_cnt_a",   cnt_a,   0);
    chk("rst_ovf_a",   ovf_a,   0);
    chk("rst_start_b", start_b, 0);
    chk("rst_cnt_b",   cnt_b,   0);

    // First edge after reset release takes the push
    rst_a = 1; rst_b = 1;
    valid_b = 1; din_b = 32'h0000_00C3;
    tick();
    valid_b = 0;
    chk("first_push_cnt", cnt_b, 1);
    tick();
    chk("first_pop_cnt", cnt_b, 0);
    chk("first_pop_start", start_b, 1);
    model_msg(1, 64'h0000_00C3, 32, 0);
    done_b = 1;
    wait_rx(1, 10, 100, "first");
    repeat (5) tick();
    cmp_stream(1, "first");

    // Table of single reads with the UART always ready
    done_a = 1;
    foreach (vecs[v]) begin
      valid_a = 1; rw_a = 0; din_a = vecs[v].data;
      tick();
      valid_a = 0;
      chk($sformatf("lat_n1_v%0d", v), start_a, 0);
      tick();
      chk($sformatf("lat_n2_v%0d", v), start_a, 1);
      exp_a.push_back(8'h44);
      for (int j = 0; j < 4; j++) exp_a.push_back(vecs[v].hex[j]);
      exp_a.push_back(8'h0D);
      exp_a.push_back(8'h0A);
      wait_rx(0, 7, 50, $sformatf("vec%0d", v));
      repeat (3) tick();
      cmp_stream(0, $sformatf("vec%0d", v));
    end

    // Writes interleaved around a single read
    begin
      logic        wr_pat [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [15:0] d_pat  [5] = '{16'hFFFF, 16'hFFFF, 16'hBEEF, 16'hFFFF, 16'hFFFF};
      for (int i = 0; i < 5; i++) begin
        valid_a = 1; rw_a = wr_pat[i]; din_a = d_pat[i];
        tick();
      end
      valid_a = 0; rw_a = 0;
      model_msg(0, 64'hBEEF, 16, 1);
      wait_rx(0, 7, 50, "wr_mix");
      repeat (10) tick();
      cmp_stream(0, "wr_mix");
      chk("wr_mix_cnt", cnt_a, 0);
      chk("wr_mix_ovf", ovf_a, 0);
    end

    // Back-to-back reads against a slow UART: one done pulse per 330 clocks
    done_a = 0; gaps = 0; started = 0;
    for (int c = 0; c < 8000; c++) begin
      valid_a = (c < 3); rw_a = 0; din_a = 16'(c + 1);
      done_a  = ((c % 330) == 329);
      tick();
      if (rx_a.size() >= 21) break;
      if (started && !start_a) gaps++;
      if (start_a) started = 1;
    end
    valid_a = 0; done_a = 0;
    chk("bb_gap", 64'(gaps), 0);
    chk("bb_started", 64'(started), 1);
    model_msg(0, 64'h1, 16, 1);
    model_msg(0, 64'h2, 16, 1);
    model_msg(0, 64'h3, 16, 1);
    repeat (3) tick();
    cmp_stream(0, "bb");

    // 32-bit, LF-only line
    done_b = 1; valid_b = 1; rw_b = 0; din_b = 32'hDEAD_BEEF;
    tick();
    valid_b = 0;
    model_msg(1, 64'hDEAD_BEEF, 32, 0);
    wait_rx(1, 10, 50, "w32");
    repeat (5) tick();
    cmp_stream(1, "w32");

    // Stalled UART, six reads into a 4-deep queue
    done_b = 0;
    for (int i = 0; i < 6; i++) begin
      valid_b = 1; rw_b = 0; din_b = 32'(i + 1);
      tick();
      chk($sformatf("ovfq_cnt%0d", i), cnt_b, exp_cnt[i]);
      chk($sformatf("ovfq_ovf%0d", i), ovf_b, exp_ovf[i]);
    end
    valid_b = 0;
    repeat (20) tick();
    chk("ovfq_stalled_rx", 64'(rx_b.size()), 0);
    chk("ovfq_stalled_cnt", cnt_b, 4);
    for (int i = 0; i < 5; i++) model_msg(1, 64'(i + 1), 32, 0);
    done_b = 1;
    wait_rx(1, 50, 300, "ovfq");
    repeat (20) tick();
    cmp_stream(1, "ovfq");
    chk("ovfq_sticky", ovf_b, 1);
    chk("ovfq_drained", cnt_b, 0);

    // Reset in the middle of a message with two entries queued
    rx_a.delete();
    done_a = 1;
    for (int i = 0; i < 3; i++) begin
      valid_a = 1; rw_a = 0; din_a = 16'h1110 + 16'(i);
      tick();
    end
    valid_a = 0;
    wait_rx(0, 3, 20, "midrst");
    chk("midrst_pre_cnt", cnt_a, 2);
    chk("midrst_pre_start", start_a, 1);
    #2 rst_a = 0;
    #1;
    chk("midrst_start", start_a, 0);
    chk("midrst_cnt",   cnt_a,   0);
    chk("midrst_data",  dout_a,  0);
    tick();
    tick();
    rst_a = 1;
    repeat (30) tick();
    chk("midrst_silent", 64'(rx_a.size()), 3);
    chk("midrst_idle", start_a, 0);
    rx_a.delete();
    valid_a = 1; din_a = 16'h0042;
    tick();
    valid_a = 0;
    model_msg(0, 64'h0042, 16, 1);
    wait_rx(0, 7, 50, "midrst_new");
    repeat (5) tick();
    cmp_stream(0, "midrst_new");

    // Random traffic, reads throttled so the queue never fills
    issued = 0;
    rx_a.delete(); exp_a.delete();
    for (int c = 0; c < 3000; c++) begin
      valid_a = ($urandom_range(0, 3) == 0);
      rw_a    = 1'($urandom_range(0, 1));
      din_a   = 16'($urandom);
      pending = issued - rx_a.size() / 7;
      if (valid_a && !rw_a && pending >= 6) valid_a = 0;
      if (valid_a && !rw_a) begin
        issued++;
        model_msg(0, 64'(din_a), 16, 1);
      end
      done_a = 1'($urandom_range(0, 1));
      tick();
    end
    valid_a = 0; rw_a = 0; done_a = 1;
    wait_rx(0, exp_a.size(), 3000, "rand");
    repeat (10) tick();
    chk("rand_issued", 64'(issued > 0), 1);
    cmp_stream(0, "rand");
    chk("rand_ovf", ovf_a, 0);
    chk("rand_cnt", cnt_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
